// File: rtl/lpf_stim_gen.sv
// lpf_stim_gen
// Stimulus source for the 8-sample-per-clock lowpass filter path. Emits
// bursts of parallel sample beats (lane k at dat_o[NBITS*k +: NBITS]) over a
// valid/ready handshake. Patterns: zero, single-lane impulse, and the 1100 MHz
// reference sine (30-entry table holding 11 periods).
//
// Optional feature macro: LPF_STIM_RAMP_EN
//   defined   : mode 3 emits a ramp, lane k of beat n = (8n+k) mod 2^NBITS
//   undefined : mode 3 behaves like zero mode and no ramp logic is built
//
// Ports
//   clk_i    in   sample clock
//   rst_i    in   asynchronous active-high reset
//   mode_i   in   [1:0] 0=zero 1=impulse 2=sine 3=ramp/zero
//   lane_i   in   [2:0] impulse lane
//   burst_i  in   [BURST_WIDTH-1:0] beats per burst, 0 = free-run
//   start_i  in   start request (ignored while busy)
//   abort_i  in   terminate the running burst
//   ready_i  in   downstream ready
//   valid_o  out  beat valid
//   dat_o    out  [NBITS*NSAMP-1:0] sample beat
//   busy_o   out  burst in progress
//   done_o   out  one-cycle burst-complete pulse
module lpf_stim_gen #(
   parameter int NBITS       = 12,
   parameter int NSAMP       = 8,
   parameter int AMPL        = 1000,
   parameter int BURST_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             mode_i,
   input  logic [2:0]             lane_i,
   input  logic [BURST_WIDTH-1:0] burst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   ready_i,
   output logic                   valid_o,
   output logic [NBITS*NSAMP-1:0] dat_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int BEAT_W = NBITS * NSAMP;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]             state_q;
   logic [1:0]             mode_q;
   logic [2:0]             lane_q;
   logic [BURST_WIDTH-1:0] burst_q;
   logic [BURST_WIDTH-1:0] count_q;
   logic [4:0]             phase_q;

   logic [5:0]             phase_sum;
   logic [4:0]             phase_adv;
   logic [1:0]             sel_mode;
   logic [2:0]             sel_lane;
   logic [4:0]             sel_phase;
   logic                   sel_first;
   logic                   last_beat;
   logic [BEAT_W-1:0]      next_beat;

`ifdef LPF_STIM_RAMP_EN
   logic [NBITS-1:0]       ramp_q;
   logic [NBITS-1:0]       ramp_next;
`endif

   // 30-entry reference sine: T[0..7] listed, T[8..15] mirrors T[7..0],
   // T[16..29] is the negation of T[1..14].
   function automatic logic signed [NBITS-1:0] sine_lut(input logic [4:0] idx);
      int v;
      case (idx)
         5'd0:  v = 0;     5'd1:  v = 743;   5'd2:  v = -995;  5'd3:  v = 588;
         5'd4:  v = 208;   5'd5:  v = -866;  5'd6:  v = 951;   5'd7:  v = -407;
         5'd8:  v = -407;  5'd9:  v = 951;   5'd10: v = -866;  5'd11: v = 208;
         5'd12: v = 588;   5'd13: v = -995;  5'd14: v = 743;   5'd15: v = 0;
         5'd16: v = -743;  5'd17: v = 995;   5'd18: v = -588;  5'd19: v = -208;
         5'd20: v = 866;   5'd21: v = -951;  5'd22: v = 407;   5'd23: v = 407;
         5'd24: v = -951;  5'd25: v = 866;   5'd26: v = -208;  5'd27: v = -588;
         5'd28: v = 995;   5'd29: v = -743;
         default: v = 0;
      endcase
      return NBITS'(v);
   endfunction

   // Beat for the table-driven modes; lane k reads T[(phase+k) mod 30].
   function automatic logic [BEAT_W-1:0] build_beat(input logic [1:0] mode,
                                                    input logic [2:0] lane,
                                                    input logic [4:0] phase,
                                                    input logic       first);
      logic [BEAT_W-1:0] beat;
      logic [5:0]        idx;
      beat = '0;
      for (int k = 0; k < NSAMP; k++) begin
         idx = {1'b0, phase} + 6'(k);
         if (idx >= 6'd30) idx = idx - 6'd30;
         case (mode)
            2'd1: if (first && lane == 3'(k)) beat[NBITS*k +: NBITS] = NBITS'(AMPL);
            2'd2: beat[NBITS*k +: NBITS] = sine_lut(idx[4:0]);
            default: ;
         endcase
      end
      return beat;
   endfunction

`ifdef LPF_STIM_RAMP_EN
   function automatic logic [BEAT_W-1:0] ramp_beat(input logic [NBITS-1:0] base);
      logic [BEAT_W-1:0] beat;
      beat = '0;
      for (int k = 0; k < NSAMP; k++) begin
         beat[NBITS*k +: NBITS] = base + NBITS'(k);
      end
      return beat;
   endfunction
`endif

   // The registered beat is always computed one step ahead: from the start
   // inputs when idle (phase 0, first beat), from the advanced phase in RUN.
   always_comb begin
      phase_sum = {1'b0, phase_q} + 6'd8;
      if (phase_sum >= 6'd30) phase_sum = phase_sum - 6'd30;
      phase_adv = phase_sum[4:0];

      if (state_q == ST_IDLE) begin
         sel_mode  = mode_i;
         sel_lane  = lane_i;
         sel_phase = 5'd0;
         sel_first = 1'b1;
      end else begin
         sel_mode  = mode_q;
         sel_lane  = lane_q;
         sel_phase = phase_adv;
         sel_first = 1'b0;
      end

      next_beat = build_beat(sel_mode, sel_lane, sel_phase, sel_first);
`ifdef LPF_STIM_RAMP_EN
      ramp_next = (state_q == ST_IDLE) ? '0 : ramp_q + NBITS'(NSAMP);
      if (sel_mode == 2'd3) next_beat = ramp_beat(ramp_next);
`endif
   end

   // Free-run bursts (burst 0) never terminate on the count.
   assign last_beat = (burst_q != '0) && (count_q == burst_q - BURST_WIDTH'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         mode_q  <= '0;
         lane_q  <= '0;
         burst_q <= '0;
         count_q <= '0;
         phase_q <= '0;
         valid_o <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         dat_o   <= '0;
`ifdef LPF_STIM_RAMP_EN
         ramp_q  <= '0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  mode_q  <= mode_i;
                  lane_q  <= lane_i;
                  burst_q <= burst_i;
                  count_q <= '0;
                  phase_q <= '0;
                  valid_o <= 1'b1;
                  busy_o  <= 1'b1;
                  dat_o   <= next_beat;
                  state_q <= ST_RUN;
`ifdef LPF_STIM_RAMP_EN
                  ramp_q  <= '0;
`endif
               end
            end
            default: begin
               // Abort wins over a simultaneous acceptance.
               if (abort_i || (valid_o && ready_i && last_beat)) begin
                  valid_o <= 1'b0;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  dat_o   <= '0;
                  state_q <= ST_IDLE;
               end else if (valid_o && ready_i) begin
                  count_q <= count_q + BURST_WIDTH'(1);
                  phase_q <= phase_adv;
                  dat_o   <= next_beat;
`ifdef LPF_STIM_RAMP_EN
                  ramp_q  <= ramp_next;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lpf_stim_gen.sv
// Testbench for lpf_stim_gen: expected beats are queued when a burst starts
// and compared against every beat the DUT hands over on an accepted cycle.
module tb_lpf_stim_gen;

   localparam int NBITS  = 12;
   localparam int NSAMP  = 8;
   localparam int BW     = 16;
   localparam int BEAT_W = NBITS * NSAMP;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        mode = '0;
   logic [2:0]        lane = '0;
   logic [BW-1:0]     burst = '0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              ready = 1'b0;
   logic              valid;
   logic [BEAT_W-1:0] dat;
   logic              busy;
   logic              done;

   lpf_stim_gen #(.NBITS(NBITS), .NSAMP(NSAMP), .AMPL(1000), .BURST_WIDTH(BW)) dut (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .lane_i(lane), .burst_i(burst),
      .start_i(start), .abort_i(abort), .ready_i(ready),
      .valid_o(valid), .dat_o(dat), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int acc_cnt  = 0;
   int done_cnt = 0;
   logic [BEAT_W-1:0] exp_q[$];

   int sine_t[30] = '{0, 743, -995, 588, 208, -866, 951, -407,
                      -407, 951, -866, 208, 588, -995, 743, 0,
                      -743, 995, -588, -208, 866, -951, 407, 407,
                      -951, 866, -208, -588, 995, -743};

   task automatic check_val(input string tag, input logic [BEAT_W-1:0] got,
                            input logic [BEAT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [BEAT_W-1:0] exp_beat(input int m, input int l, input int n);
      logic [BEAT_W-1:0] r;
      int p;
      r = '0;
      p = (8 * n) % 30;
      for (int k = 0; k < NSAMP; k++) begin
         case (m)
            1: if (n == 0 && k == l) r[NBITS*k +: NBITS] = 12'd1000;
            2: r[NBITS*k +: NBITS] = NBITS'(sine_t[(p + k) % 30]);
`ifdef LPF_STIM_RAMP_EN
            3: r[NBITS*k +: NBITS] = NBITS'(8 * n + k);
`endif
            default: ;
         endcase
      end
      return r;
   endfunction

   // Output monitor, sampled on the falling edge; inputs only change just
   // after the rising edge, so what is seen here is what the next edge sees.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (valid && !abort) begin
            if (ready) begin
               check_val("sb_nonempty", BEAT_W'(exp_q.size() != 0), BEAT_W'(1));
               if (exp_q.size() != 0) check_val("beat", dat, exp_q.pop_front());
               acc_cnt++;
            end else if (exp_q.size() != 0) begin
               check_val("hold", dat, exp_q[0]);
            end
         end
      end
   end

   task automatic start_burst(input int m, input int l, input int b, input int npush);
      mode  = 2'(m);
      lane  = 3'(l);
      burst = BW'(b);
      start = 1'b1;
      for (int i = 0; i < npush; i++) exp_q.push_back(exp_beat(m, l, i));
      @(posedge clk) #1;
      start = 1'b0;
      check_val("start_valid", BEAT_W'(valid), BEAT_W'(1));
      check_val("start_busy", BEAT_W'(busy), BEAT_W'(1));
   endtask

   task automatic wait_acc(input string tag, input int target);
      int cyc;
      cyc = 0;
      while (acc_cnt < target && cyc < 500) begin
         @(posedge clk) #1;
         cyc++;
      end
      check_val({tag, "_acc_tmo"}, BEAT_W'(acc_cnt >= target), BEAT_W'(1));
   endtask

   task automatic wait_idle(input string tag);
      int cyc;
      cyc = 0;
      while (busy && cyc < 500) begin
         @(posedge clk) #1;
         cyc++;
      end
      check_val({tag, "_idle_tmo"}, BEAT_W'(cyc < 500), BEAT_W'(1));
      check_val({tag, "_done_hi"}, BEAT_W'(done), BEAT_W'(1));
      check_val({tag, "_valid_lo"}, BEAT_W'(valid), BEAT_W'(0));
      check_val({tag, "_sb_empty"}, BEAT_W'(exp_q.size()), BEAT_W'(0));
      @(posedge clk) #1;
      check_val({tag, "_done_lo"}, BEAT_W'(done), BEAT_W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, d0;
      logic did;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_valid", BEAT_W'(valid), BEAT_W'(0));
      check_val("rst_busy", BEAT_W'(busy), BEAT_W'(0));
      check_val("rst_done", BEAT_W'(done), BEAT_W'(0));
      check_val("rst_dat", dat, '0);
      rst = 1'b0;
      @(posedge clk) #1;
      ready = 1'b1;

      // Impulse on lane 3, 4 beats
      a0 = acc_cnt; d0 = done_cnt;
      check_val("imp_beat0_model", exp_beat(1, 3, 0), BEAT_W'(1000) << 36);
      start_burst(1, 3, 4, 4);
      wait_idle("imp");
      check_val("imp_beats", BEAT_W'(acc_cnt - a0), BEAT_W'(4));
      check_val("imp_dones", BEAT_W'(done_cnt - d0), BEAT_W'(1));

      // Sine, 16 beats (beat 15 wraps back to phase 0)
      start_burst(2, 0, 16, 16);
      wait_idle("sine16");

      // Backpressure: ready low two cycles while beat 1 is presented
      a0 = acc_cnt; d0 = done_cnt;
      start_burst(2, 0, 5, 5);
      wait_acc("bp", a0 + 1);
      ready = 1'b0;
      repeat (2) @(posedge clk) #1;
      ready = 1'b1;
      wait_idle("bp");
      check_val("bp_beats", BEAT_W'(acc_cnt - a0), BEAT_W'(5));
      check_val("bp_dones", BEAT_W'(done_cnt - d0), BEAT_W'(1));

      // Free-run sine, ignored start mid-run, abort after 20 beats
      a0 = acc_cnt; d0 = done_cnt; did = 1'b0;
      start_burst(2, 0, 0, 20);
      for (int cyc = 0; cyc < 500 && acc_cnt - a0 < 20; cyc++) begin
         if (acc_cnt - a0 == 5 && !did) begin
            start = 1'b1; mode = 2'd1; burst = BW'(2); did = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk) #1;
      end
      start = 1'b0;
      check_val("ab_reach20", BEAT_W'(acc_cnt - a0), BEAT_W'(20));
      abort = 1'b1;
      @(posedge clk) #1;
      abort = 1'b0;
      check_val("ab_valid_lo", BEAT_W'(valid), BEAT_W'(0));
      check_val("ab_busy_lo", BEAT_W'(busy), BEAT_W'(0));
      check_val("ab_done_hi", BEAT_W'(done), BEAT_W'(1));
      @(posedge clk) #1;
      check_val("ab_done_lo", BEAT_W'(done), BEAT_W'(0));
      check_val("ab_beats", BEAT_W'(acc_cnt - a0), BEAT_W'(20));
      check_val("ab_dones", BEAT_W'(done_cnt - d0), BEAT_W'(1));
      check_val("ab_sb_empty", BEAT_W'(exp_q.size()), BEAT_W'(0));

      // Reset in the middle of a 10-beat burst
      a0 = acc_cnt;
      start_burst(2, 0, 10, 10);
      wait_acc("rstm", a0 + 2);
      rst = 1'b1;
      #1;
      check_val("rstm_valid", BEAT_W'(valid), BEAT_W'(0));
      check_val("rstm_busy", BEAT_W'(busy), BEAT_W'(0));
      check_val("rstm_dat", dat, '0);
      exp_q.delete();
      d0 = done_cnt;
      @(posedge clk) #1;
      rst = 1'b0;
      @(posedge clk) #1;
      check_val("rstm_no_done", BEAT_W'(done_cnt - d0), BEAT_W'(0));
      start_burst(2, 0, 3, 3);
      wait_idle("rstm_restart");

      // Zero mode and mode 3 (ramp when built, zeros otherwise)
      start_burst(0, 0, 2, 2);
      wait_idle("zero");
      start_burst(3, 0, 3, 3);
      wait_idle("mode3");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
